counter_prog: RTL

Parametrised programmable counter; successor to the basic enable-only counter.
Adds load, synchronous clear, up/down direction, programmable limit, wrap/saturate/one-shot modes, prescaler, compare match and terminal-count pulse.
Used as the general timing/event counter for control FSMs and timeout generation across the design.

---
 rtl/counter_prog.sv | 113 +++++++++++
 1 files changed

// File: rtl/counter_prog.sv
// Programmable timing/event counter: load, clear, up/down, limit,
// wrap/saturate/one-shot modes, prescaler, compare match, terminal pulse.
module counter_prog #(
  parameter int CNT_WIDTH = 8,
  parameter int PSC_WIDTH = 4
) (
  input  logic                 cnt_clk,
  input  logic                 cnt_rst_n,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  input  logic                 cnt_load,
  input  logic [CNT_WIDTH-1:0] cnt_load_val,
  input  logic                 cnt_dir,
  input  logic [1:0]           cnt_mode,
  input  logic [CNT_WIDTH-1:0] cnt_limit,
  input  logic [PSC_WIDTH-1:0] cnt_presc,
  input  logic [CNT_WIDTH-1:0] cnt_cmp,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 cnt_tc,
  output logic                 cnt_match,
  output logic                 cnt_done
);

  localparam int W = CNT_WIDTH;
  localparam int P = PSC_WIDTH;

  logic [P-1:0] psc;
  logic [P-1:0] nxt_psc;
  logic [W-1:0] nxt_cnt;
  logic [W-1:0] step_val;
  logic [W-1:0] term;
  logic [W-1:0] load_clamp;
  logic         nxt_tc;
  logic         nxt_done;
  logic         wrapped;
  logic         step_tc;
  logic         wrap_m;
  logic         one_m;

  assign wrap_m = (cnt_mode == 2'b00) || (cnt_mode == 2'b11);
  assign one_m  = (cnt_mode == 2'b10);
  assign term   = cnt_dir ? cnt_limit : '0;

  assign load_clamp = (cnt_load_val > cnt_limit) ?
                      cnt_limit : cnt_load_val;

  always_comb begin
    step_val = cnt_o;
    wrapped  = 1'b0;
    if (cnt_dir) begin
      if (cnt_o >= cnt_limit) begin
        step_val = wrap_m ? '0 : cnt_limit;
        wrapped  = 1'b1;
      end else begin
        step_val = cnt_o + 1'b1;
      end
    end else begin
      if (cnt_o == '0) begin
        step_val = wrap_m ? cnt_limit : '0;
        wrapped  = 1'b1;
      end else if (cnt_o > cnt_limit) begin
        step_val = cnt_limit;
      end else begin
        step_val = cnt_o - 1'b1;
      end
    end
    // Held-at-terminal steps in saturate/one-shot must not pulse
    step_tc = wrap_m ? wrapped :
              ((step_val == term) && (cnt_o != term));
  end

  always_comb begin
    nxt_cnt  = cnt_o;
    nxt_psc  = psc;
    nxt_tc   = 1'b0;
    nxt_done = cnt_done;
    if (cnt_clr) begin
      nxt_cnt  = '0;
      nxt_psc  = '0;
      nxt_done = 1'b0;
    end else if (cnt_load) begin
      nxt_cnt  = load_clamp;
      nxt_psc  = '0;
      nxt_done = 1'b0;
    end else if (cnt_en && !cnt_done) begin
      if (psc >= cnt_presc) begin
        nxt_psc = '0;
        nxt_cnt = step_val;
        nxt_tc  = step_tc;
        if (one_m && step_tc) nxt_done = 1'b1;
      end else begin
        nxt_psc = psc + 1'b1;
      end
    end
  end

  always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      cnt_o     <= '0;
      psc       <= '0;
      cnt_tc    <= 1'b0;
      cnt_done  <= 1'b0;
      cnt_match <= 1'b0;
    end else begin
      cnt_o     <= nxt_cnt;
      psc       <= nxt_psc;
      cnt_tc    <= nxt_tc;
      cnt_done  <= nxt_done;
      cnt_match <= (nxt_cnt == cnt_cmp);
    end
  end

endmodule
